// File: rtl/box_mover_object_if.sv
// Signal bundle between the moving-box sprite and the scan/collision/key
// logic around it. The box mover is the master. It drives the draw request,
// the colour and the position, and it receives the scan position, the frame
// strobe and the key/collision events.
`timescale 1ns/1ps

interface box_mover_object_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        collision;
    logic        keyPause;
    logic        keyFlipX;
    logic        box_drawingRequest;
    logic [7:0]  boxRGB;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;

    modport master (
        input  pixelX, pixelY, startOfFrame, collision, keyPause, keyFlipX,
        output box_drawingRequest, boxRGB, topLeftX, topLeftY
    );

    modport slave (
        output pixelX, pixelY, startOfFrame, collision, keyPause, keyFlipX,
        input  box_drawingRequest, boxRGB, topLeftX, topLeftY
    );
endinterface

// File: rtl/box_mover_object.sv
// Moving-box sprite. It holds the position and velocity and advances them
// once per frame, bouncing off the screen edges. A collision reverses the
// vertical direction and starts a short colour flash. The block also
// produces a registered draw request and colour for the current scan pixel.
`timescale 1ns/1ps

module box_mover_object #(
    parameter int          BOX_W        = 32,
    parameter int          BOX_H        = 32,
    parameter int          INIT_X       = 100,
    parameter int          INIT_Y       = 100,
    parameter int          INIT_VX      = 2,
    parameter int          INIT_VY      = 1,
    parameter int          SCREEN_W     = 640,
    parameter int          SCREEN_H     = 480,
    parameter logic [7:0]  BOX_COLOR    = 8'hE0,
    parameter logic [7:0]  FLASH_COLOR  = 8'hFF,
    parameter int          FLASH_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    box_mover_object_if.master   bus
);

    localparam int unsigned POS_W = 12;
    localparam int unsigned CNT_W = 8;

    localparam logic signed [POS_W-1:0] MAX_X   = POS_W'(SCREEN_W - BOX_W);
    localparam logic signed [POS_W-1:0] MAX_Y   = POS_W'(SCREEN_H - BOX_H);
    localparam logic signed [POS_W-1:0] BOX_W_S = POS_W'(BOX_W);
    localparam logic signed [POS_W-1:0] BOX_H_S = POS_W'(BOX_H);
    localparam logic signed [POS_W-1:0] ZERO_S  = '0;
    localparam logic [CNT_W-1:0]        CNT_INIT = CNT_W'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {
        S_MOVING = 2'd0,
        S_PAUSED = 2'd1,
        S_FLASH  = 2'd2
    } state_t;

    state_t                   r_state;
    logic signed [POS_W-1:0]  r_x;
    logic signed [POS_W-1:0]  r_y;
    logic signed [POS_W-1:0]  r_vx;
    logic signed [POS_W-1:0]  r_vy;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_col_latch;
    logic                     r_flip_latch;
    logic                     r_flip_d;
    logic                     r_draw;
    logic [7:0]               r_rgb;

    logic                     w_flip_rise;
    logic                     w_col_evt;
    logic                     w_flip_evt;
    logic signed [POS_W-1:0]  w_vx_f;
    logic signed [POS_W-1:0]  w_vx_abs;
    logic signed [POS_W-1:0]  w_vy_abs;
    logic signed [POS_W-1:0]  w_nx;
    logic signed [POS_W-1:0]  w_ny;
    logic signed [POS_W-1:0]  w_upd_x;
    logic signed [POS_W-1:0]  w_upd_y;
    logic signed [POS_W-1:0]  w_upd_vx;
    logic signed [POS_W-1:0]  w_upd_vy;
    logic signed [POS_W-1:0]  w_px;
    logic signed [POS_W-1:0]  w_py;
    logic                     w_inside;
    logic [7:0]               w_rgb;

    // Events that arrive on the frame-strobe cycle itself count in that frame.
    always_comb begin
        w_flip_rise = bus.keyFlipX & ~r_flip_d;
        w_col_evt   = r_col_latch  | bus.collision;
        w_flip_evt  = r_flip_latch | w_flip_rise;
    end

    // Next position: apply the flip, step, then clamp at the walls so the wall always wins.
    // This path never applies a collision: MOVING takes it only when no collision is
    // pending, and FLASH discards collisions.
    always_comb begin
        w_vx_f   = w_flip_evt ? -r_vx : r_vx;
        w_vx_abs = w_vx_f[POS_W-1] ? -w_vx_f : w_vx_f;
        w_vy_abs = r_vy[POS_W-1]   ? -r_vy   : r_vy;
        w_nx     = r_x + w_vx_f;
        w_ny     = r_y + r_vy;

        w_upd_x  = w_nx;
        w_upd_vx = w_vx_f;
        if (w_nx < ZERO_S) begin
            w_upd_x  = ZERO_S;
            w_upd_vx = w_vx_abs;
        end else if (w_nx > MAX_X) begin
            w_upd_x  = MAX_X;
            w_upd_vx = -w_vx_abs;
        end

        w_upd_y  = w_ny;
        w_upd_vy = r_vy;
        if (w_ny < ZERO_S) begin
            w_upd_y  = ZERO_S;
            w_upd_vy = w_vy_abs;
        end else if (w_ny > MAX_Y) begin
            w_upd_y  = MAX_Y;
            w_upd_vy = -w_vy_abs;
        end
    end

    // Hit test of the current scan pixel against the box, and the colour to show there.
    always_comb begin
        w_px     = {1'b0, bus.pixelX};
        w_py     = {1'b0, bus.pixelY};
        w_inside = (w_px >= r_x) && (w_px < r_x + BOX_W_S) &&
                   (w_py >= r_y) && (w_py < r_y + BOX_H_S);
        w_rgb    = 8'h00;
        if (w_inside) begin
            w_rgb = ((r_state == S_FLASH) && r_cnt[0]) ? FLASH_COLOR : BOX_COLOR;
        end
    end

    // Motion FSM, event latches and the registered pixel outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_MOVING;
            r_x          <= POS_W'(INIT_X);
            r_y          <= POS_W'(INIT_Y);
            r_vx         <= POS_W'(INIT_VX);
            r_vy         <= POS_W'(INIT_VY);
            r_cnt        <= '0;
            r_col_latch  <= 1'b0;
            r_flip_latch <= 1'b0;
            r_flip_d     <= 1'b0;
            r_draw       <= 1'b0;
            r_rgb        <= 8'h00;
        end else begin
            r_flip_d <= bus.keyFlipX;
            r_draw   <= w_inside;
            r_rgb    <= w_rgb;

            if (bus.startOfFrame) begin
                r_col_latch  <= 1'b0;
                r_flip_latch <= 1'b0;
                case (r_state)
                    S_MOVING: begin
                        if (w_col_evt) begin
                            r_vy    <= -r_vy;
                            r_cnt   <= CNT_INIT;
                            r_state <= S_FLASH;
                        end else if (bus.keyPause) begin
                            r_state <= S_PAUSED;
                        end else begin
                            r_x  <= w_upd_x;
                            r_y  <= w_upd_y;
                            r_vx <= w_upd_vx;
                            r_vy <= w_upd_vy;
                        end
                    end
                    S_PAUSED: begin
                        if (!bus.keyPause) begin
                            r_state <= S_MOVING;
                        end
                    end
                    S_FLASH: begin
                        r_x  <= w_upd_x;
                        r_y  <= w_upd_y;
                        r_vx <= w_upd_vx;
                        r_vy <= w_upd_vy;
                        if (r_cnt == '0) begin
                            r_state <= S_MOVING;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    default: r_state <= S_MOVING;
                endcase
            end else begin
                if (bus.collision) r_col_latch  <= 1'b1;
                if (w_flip_rise)   r_flip_latch <= 1'b1;
            end
        end
    end

    // The position outputs are the low 11 bits of the position registers.
    always_comb begin
        bus.box_drawingRequest = r_draw;
        bus.boxRGB             = r_rgb;
        bus.topLeftX           = r_x[10:0];
        bus.topLeftY           = r_y[10:0];
    end

endmodule

// File: tb/tb_box_mover_object.sv
// Directed bench for the moving-box sprite: drawing, motion, wall bounces,
// collision flash, pause, X flip and mid-frame reset.
`timescale 1ns/1ps

module tb_box_mover_object;

    logic clk = 1'b0;
    logic resetN;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    box_mover_object_if bus ();

    box_mover_object dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pulse_collision();
        bus.collision = 1'b1;
        tick();
        bus.collision = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        bus.pixelX = 11'd100; bus.pixelY = 11'd100;
        bus.startOfFrame = 1'b0; bus.collision = 1'b0;
        bus.keyPause = 1'b0; bus.keyFlipX = 1'b0;
        tick(); tick();
        if (bus.topLeftX !== 11'd100 || bus.topLeftY !== 11'd100 ||
            bus.box_drawingRequest !== 1'b0 || bus.boxRGB !== 8'h00) begin
            $display("FAIL reset: pos=(%0d,%0d) req=%b rgb=%h, want (100,100) 0 00",
                     bus.topLeftX, bus.topLeftY, bus.box_drawingRequest, bus.boxRGB);
            n_err++;
        end
        n_vec++;
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_draw();
        int px [6] = '{100, 131, 132,  99, 100, 131};
        int py [6] = '{100, 131, 100, 100, 132, 100};
        logic       ereq [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] ergb [6] = '{8'hE0, 8'hE0, 8'h00, 8'h00, 8'h00, 8'hE0};
        for (int i = 0; i < 6; i++) begin
            bus.pixelX = 11'(px[i]);
            bus.pixelY = 11'(py[i]);
            tick();
            if (bus.box_drawingRequest !== ereq[i] || bus.boxRGB !== ergb[i]) begin
                $display("FAIL draw[%0d] (%0d,%0d): req=%b rgb=%h, want %b %h",
                         i, px[i], py[i], bus.box_drawingRequest, bus.boxRGB, ereq[i], ergb[i]);
                n_err++;
            end
            n_vec++;
        end
        if (bus.topLeftX !== 11'd100 || bus.topLeftY !== 11'd100) begin
            $display("FAIL draw_pos: pos=(%0d,%0d), want (100,100)", bus.topLeftX, bus.topLeftY);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_motion();
        int cnt [2] = '{1, 9};
        int ex  [2] = '{102, 120};
        int ey  [2] = '{101, 110};
        for (int i = 0; i < 2; i++) begin
            run_frames(cnt[i]);
            if (bus.topLeftX !== 11'(ex[i]) || bus.topLeftY !== 11'(ey[i])) begin
                $display("FAIL motion[%0d]: pos=(%0d,%0d), want (%0d,%0d)",
                         i, bus.topLeftX, bus.topLeftY, ex[i], ey[i]);
                n_err++;
            end
            n_vec++;
        end
    endtask

    // From (120,110), vx=+2, vy=+1: the right wall, then the bottom and left walls.
    task automatic test_walls();
        int cnt [10] = '{243,   1,   1,   1,  92,   1,   1, 209,   1,   1};
        int ex  [10] = '{606, 608, 608, 606, 422, 420, 418,   0,   0,   2};
        int ey  [10] = '{353, 354, 355, 356, 448, 448, 447, 238, 237, 236};
        for (int i = 0; i < 10; i++) begin
            run_frames(cnt[i]);
            if (bus.topLeftX !== 11'(ex[i]) || bus.topLeftY !== 11'(ey[i])) begin
                $display("FAIL walls[%0d]: pos=(%0d,%0d), want (%0d,%0d)",
                         i, bus.topLeftX, bus.topLeftY, ex[i], ey[i]);
                n_err++;
            end
            n_vec++;
        end
    endtask

    // From (2,236), vx=+2, vy=-1: a collision flips vy to +1 and starts an 8-frame flash.
    task automatic test_flash();
        int ex, ey;
        logic [7:0] ergb;
        pulse_collision();
        frame();
        for (int f = 0; f < 10; f++) begin
            if (f > 0) begin
                if (f == 3) pulse_collision();
                frame();
            end
            ex   = (f == 0) ? 2 : 2 + 2 * f;
            ey   = (f == 0) ? 236 : 236 + f;
            ergb = (f <= 7 && (f % 2) == 0) ? 8'hFF : 8'hE0;
            if (bus.topLeftX !== 11'(ex) || bus.topLeftY !== 11'(ey)) begin
                $display("FAIL flash_pos[%0d]: pos=(%0d,%0d), want (%0d,%0d)",
                         f, bus.topLeftX, bus.topLeftY, ex, ey);
                n_err++;
            end
            n_vec++;
            bus.pixelX = 11'(ex + 5);
            bus.pixelY = 11'(ey + 5);
            tick();
            if (bus.box_drawingRequest !== 1'b1 || bus.boxRGB !== ergb) begin
                $display("FAIL flash_rgb[%0d]: req=%b rgb=%h, want 1 %h",
                         f, bus.box_drawingRequest, bus.boxRGB, ergb);
                n_err++;
            end
            n_vec++;
        end
    endtask

    // Box frozen at (20,245) while paused. A collision during the pause is dropped.
    task automatic test_pause();
        bus.keyPause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) pulse_collision();
            frame();
            if (bus.topLeftX !== 11'd20 || bus.topLeftY !== 11'd245) begin
                $display("FAIL pause[%0d]: pos=(%0d,%0d), want (20,245)",
                         i, bus.topLeftX, bus.topLeftY);
                n_err++;
            end
            n_vec++;
        end
        bus.keyPause = 1'b0;
        frame();
        if (bus.topLeftX !== 11'd20 || bus.topLeftY !== 11'd245) begin
            $display("FAIL unpause_hold: pos=(%0d,%0d), want (20,245)", bus.topLeftX, bus.topLeftY);
            n_err++;
        end
        n_vec++;
        frame();
        if (bus.topLeftX !== 11'd22 || bus.topLeftY !== 11'd246) begin
            $display("FAIL resume: pos=(%0d,%0d), want (22,246)", bus.topLeftX, bus.topLeftY);
            n_err++;
        end
        n_vec++;
        bus.pixelX = 11'd27; bus.pixelY = 11'd251;
        tick();
        if (bus.boxRGB !== 8'hE0) begin
            $display("FAIL resume_rgb: rgb=%h, want e0", bus.boxRGB);
            n_err++;
        end
        n_vec++;
    endtask

    // A flip that would push the box into the right wall loses to the clamp.
    // A held key does not flip again. A rise latched mid-frame flips on the next frame.
    task automatic test_flip_wall();
        int cnt [4] = '{292,   1,   1,   1};
        int ex  [4] = '{606, 608, 608, 608};
        int ey  [4] = '{359, 358, 357, 356};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.keyFlipX = 1'b1;
            run_frames(cnt[i]);
            if (bus.topLeftX !== 11'(ex[i]) || bus.topLeftY !== 11'(ey[i])) begin
                $display("FAIL flip_wall[%0d]: pos=(%0d,%0d), want (%0d,%0d)",
                         i, bus.topLeftX, bus.topLeftY, ex[i], ey[i]);
                n_err++;
            end
            n_vec++;
        end
        frame();
        if (bus.topLeftX !== 11'd606 || bus.topLeftY !== 11'd355) begin
            $display("FAIL flip_held: pos=(%0d,%0d), want (606,355)", bus.topLeftX, bus.topLeftY);
            n_err++;
        end
        n_vec++;
        frame();
        bus.keyFlipX = 1'b0; tick();
        bus.keyFlipX = 1'b1; tick();
        bus.keyFlipX = 1'b0; tick();
        frame();
        if (bus.topLeftX !== 11'd606 || bus.topLeftY !== 11'd353) begin
            $display("FAIL flip_latched: pos=(%0d,%0d), want (606,353)", bus.topLeftX, bus.topLeftY);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_reset_midframe();
        bus.pixelX = 11'd610; bus.pixelY = 11'd360;
        tick();
        if (bus.box_drawingRequest !== 1'b1) begin
            $display("FAIL pre_reset_req: req=%b, want 1", bus.box_drawingRequest);
            n_err++;
        end
        n_vec++;
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        if (bus.topLeftX !== 11'd100 || bus.topLeftY !== 11'd100 ||
            bus.box_drawingRequest !== 1'b0 || bus.boxRGB !== 8'h00) begin
            $display("FAIL async_reset: pos=(%0d,%0d) req=%b rgb=%h, want (100,100) 0 00",
                     bus.topLeftX, bus.topLeftY, bus.box_drawingRequest, bus.boxRGB);
            n_err++;
        end
        n_vec++;
        tick();
        resetN = 1'b1;
        bus.pixelX = 11'd100; bus.pixelY = 11'd100;
        tick();
        if (bus.box_drawingRequest !== 1'b1 || bus.boxRGB !== 8'hE0) begin
            $display("FAIL post_reset_draw: req=%b rgb=%h, want 1 e0",
                     bus.box_drawingRequest, bus.boxRGB);
            n_err++;
        end
        n_vec++;
        frame();
        if (bus.topLeftX !== 11'd102 || bus.topLeftY !== 11'd101) begin
            $display("FAIL post_reset_move: pos=(%0d,%0d), want (102,101)",
                     bus.topLeftX, bus.topLeftY);
            n_err++;
        end
        n_vec++;
    endtask

    initial begin
        test_reset();
        test_draw();
        test_motion();
        test_walls();
        test_flash();
        test_pause();
        test_flip_wall();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/box_mover_object.md
Name: box_mover_object

Overview:
- Self-contained moving-box sprite generator. It sits directly upstream of the VGA object priority mux and drives that mux's box_drawingRequest and boxRGB inputs.
- Keeps the box position and velocity, and updates them once per frame on startOfFrame.
- Bounces the box off the screen edges, reverses vertical direction on collision, and flashes after a hit.
- Compares the current scan pixel against the box rectangle and produces a registered drawing request and colour.

Parameters:
- BOX_W, 32, box width in pixels
- BOX_H, 32, box height in pixels
- INIT_X, 100, top-left X after reset
- INIT_Y, 100, top-left Y after reset
- INIT_VX, 2, signed X speed after reset (pixels/frame)
- INIT_VY, 1, signed Y speed after reset (pixels/frame)
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height
- BOX_COLOR, 8'hE0, normal RGB332 colour
- FLASH_COLOR, 8'hFF, alternate colour during flash
- FLASH_FRAMES, 8, frame count of the flash state

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- startOfFrame  in  1  one-cycle pulse at frame start
- collision  in  1  pulse from collision detector, any cycle
- keyPause  in  1  level; 1 = hold motion
- keyFlipX  in  1  level from key; its rising edge requests an X reversal
- box_drawingRequest  out  1  registered: pixel inside box
- boxRGB  out  8  registered colour
- topLeftX  out  11  current box X
- topLeftY  out  11  current box Y

Behaviour:
- Reset is asynchronous and active-low, on resetN, clock clk. On reset:
  - topLeftX=INIT_X, topLeftY=INIT_Y, vx=INIT_VX, vy=INIT_VY
  - state=MOVING, flash counter=0, collision latch=0, flip latch=0
  - box_drawingRequest=0, boxRGB=8'h00
- Reset asserted mid-frame or mid-flash returns everything to these values immediately.
- Internal position and velocity are 12-bit signed; outputs are the low 11 bits.
- Latches:
  - A collision pulse on any cycle sets the collision latch.
  - A keyFlipX rising edge (registered edge detect) sets the flip latch.
  - Both latches are consumed and cleared on startOfFrame.
  - An event coinciding with startOfFrame is consumed in that same frame update.
- States: MOVING, PAUSED, FLASH. All transitions and updates happen only on cycles with startOfFrame=1.
- MOVING:
  - If the collision latch is set: vy=-vy, flash counter=FLASH_FRAMES-1, go to FLASH.
  - Else if keyPause=1: go to PAUSED with no position update this frame.
  - Otherwise apply the position update.
- PAUSED:
  - No position update.
  - Collision and flip latches are cleared and discarded.
  - keyPause=0 returns to MOVING; the next update happens on the following startOfFrame.
- FLASH:
  - Position update continues; keyPause is ignored.
  - Collisions are discarded; flips are honoured.
  - Counter decrements each frame. When the counter is 0 at startOfFrame, go to MOVING without decrementing.
- Position update order within one frame:
  1. Apply the flip: vx=-vx.
  2. Apply the collision: vy=-vy.
  3. nx=X+vx, ny=Y+vy.
  4. If nx<0: X=0, vx=|vx|. Else if nx>SCREEN_W-BOX_W: X=SCREEN_W-BOX_W, vx=-|vx|. Else X=nx.
  5. Y follows the same rule with SCREEN_H and BOX_H.
- Wall clamping therefore always wins over a flip or collision that would push the box further out.
- Drawing:
  - inside = (pixelX>=X) && (pixelX<X+BOX_W) && (pixelY>=Y) && (pixelY<Y+BOX_H).
  - box_drawingRequest is registered one clk after the pixel is presented.
  - boxRGB is registered together with the request: 8'h00 when not inside.
  - When inside: FLASH_COLOR if state==FLASH and counter[0]==1, else BOX_COLOR.
- Position changes take effect from the cycle after startOfFrame, so a frame is never drawn with mixed positions.
- Total latency from pixel to the mux output is 2 clk; the downstream timing generator accounts for it.

Test Plan:
1. Release reset, present pixel (100,100) then (131,131) then (132,100) -> drawingRequest 1, 1, 0, one cycle later; boxRGB=8'hE0 on the hits, 8'h00 on the miss; topLeft=(100,100).
2. Ten startOfFrame pulses, no keys -> topLeft=(120,110), vx=2, vy=1.
3. Start at X=606, vx=+2, one frame -> X=608, vx=-2. Next frame -> X=606. Mirror check: X=1, vx=-2 -> X=0, vx=+2.
4. Collision pulse mid-frame, then startOfFrame -> vy sign flips, state FLASH, box colour alternates E0/FF on successive frames for 8 frames, then returns to MOVING. A second collision during FLASH produces no vy change.
5. keyPause=1 at startOfFrame -> position frozen for 5 frames; a collision in this period is discarded. keyPause=0 -> motion resumes one frame later with unchanged velocity.
6. keyFlipX rise together with a right-wall hit (X=607, vx=+2) -> vx=-2 after the update, X=605. Assert resetN=0 mid-frame -> outputs return to (100,100), 0, 8'h00 asynchronously.
